// File: rtl/generate_timer_if.sv
// generate_timer_if: generation-interval bus between the game controller (master) and generate_timer (slave).
// The pause signal exists only when GENERATE_TIMER_PAUSE_EN is defined.
interface generate_timer_if;
    logic        en;
    logic [31:0] gene_time;
    logic        gene_pulse;
    logic        levelup;
    logic [3:0]  level;
    logic [31:0] remain;
`ifdef GENERATE_TIMER_PAUSE_EN
    logic        pause;
    modport master (output en, gene_time, pause, input gene_pulse, levelup, level, remain);
    modport slave  (input en, gene_time, pause, output gene_pulse, levelup, level, remain);
`else
    modport master (output en, gene_time, input gene_pulse, levelup, level, remain);
    modport slave  (input en, gene_time, output gene_pulse, levelup, level, remain);
`endif
endinterface

// File: rtl/generate_timer.sv
// generate_timer: counts gene_time intervals down into gene_pulse and paces levelup/level.
// Optional PAUSE state enabled by GENERATE_TIMER_PAUSE_EN.
module generate_timer #(
    parameter int GEN_PER_LEVEL = 16,
    parameter int MAX_LEVEL     = 15
) (
    input logic             clk,
    input logic             rst,
    generate_timer_if.slave bus
);
`ifdef GENERATE_TIMER_PAUSE_EN
    typedef enum logic [1:0] {IDLE, LOAD, COUNT, PAUSE} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, COUNT} state_t;
`endif
    state_t      state_q;
    logic [31:0] remain_q;
    logic        pulse_q, lvlup_q;
    logic [3:0]  level_q, level_d, pend_q, pend_d;
    logic [15:0] gen_q, gen_d;
    logic        req, acc, issue;
    logic [4:0]  target;
    // Level-ups are queued in pend_q so back-to-back requests come out on alternate cycles.
    always_comb begin
        req     = pulse_q && gen_q == 16'(GEN_PER_LEVEL - 1);
        target  = {1'b0, level_q} + {1'b0, pend_q};
        acc     = req && target < 5'(MAX_LEVEL);
        issue   = !lvlup_q && (pend_q != '0 || acc);
        pend_d  = pend_q + 4'(acc) - 4'(issue);
        level_d = level_q + 4'(issue);
        gen_d   = !pulse_q ? gen_q : req ? '0 : gen_q + 16'd1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            remain_q <= '0;
            pulse_q  <= 1'b0;
            lvlup_q  <= 1'b0;
            level_q  <= '0;
            pend_q   <= '0;
            gen_q    <= '0;
        end else begin
            gen_q   <= gen_d;
            pend_q  <= pend_d;
            lvlup_q <= issue;
            level_q <= level_d;
            pulse_q <= 1'b0;
            if (!bus.en) begin
                state_q  <= IDLE;
                remain_q <= '0;
            end else begin
                case (state_q)
                    IDLE: state_q <= LOAD;
                    LOAD: begin
                        state_q  <= COUNT;
                        remain_q <= bus.gene_time;
                        pulse_q  <= bus.gene_time == '0;
                    end
                    COUNT:
`ifdef GENERATE_TIMER_PAUSE_EN
                        if (bus.pause) begin
                            state_q  <= PAUSE;
                            remain_q <= (remain_q == '0) ? bus.gene_time : remain_q;
                        end else
`endif
                        begin
                            remain_q <= (remain_q == '0) ? bus.gene_time : remain_q - 32'd1;
                            pulse_q  <= (remain_q == '0) ? bus.gene_time == '0 : remain_q == 32'd1;
                        end
`ifdef GENERATE_TIMER_PAUSE_EN
                    PAUSE:
                        if (!bus.pause) begin
                            state_q <= COUNT;
                            pulse_q <= remain_q == '0;
                        end
`endif
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    assign bus.gene_pulse = pulse_q;
    assign bus.levelup    = lvlup_q;
    assign bus.level      = level_q;
    assign bus.remain     = remain_q;
endmodule

// File: tb/tb_generate_timer.sv
// tb_generate_timer: directed vector table plus hand sequences for generate_timer
// (two instances: GEN_PER_LEVEL=4/MAX_LEVEL=15 and GEN_PER_LEVEL=1/MAX_LEVEL=2).
module tb_generate_timer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   tot_cnt  = 0;
    always #5 clk = ~clk;
    generate_timer_if bus_a ();
    generate_timer_if bus_b ();
    generate_timer #(.GEN_PER_LEVEL(4), .MAX_LEVEL(15)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    generate_timer #(.GEN_PER_LEVEL(1), .MAX_LEVEL(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    typedef struct {
        logic        rs;
        logic        en;
        logic [31:0] gt;
        logic [31:0] rem;
        logic        pul;
    } vec_t;
    vec_t tbl[$];
    function automatic vec_t v(logic rs, logic en, logic [31:0] gt, logic [31:0] rem, logic pul);
        vec_t r;
        r.rs = rs; r.en = en; r.gt = gt; r.rem = rem; r.pul = pul;
        return r;
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        bus_a.en = 1'b0;
        bus_b.en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask
    initial begin
        bus_a.en = 1'b0; bus_a.gene_time = '0;
        bus_b.en = 1'b0; bus_b.gene_time = '0;
`ifdef GENERATE_TIMER_PAUSE_EN
        bus_a.pause = 1'b0;
        bus_b.pause = 1'b0;
`endif
        // interval 4: remain 4,3,2,1,0,4 with first pulse 6 edges after en
        tbl.push_back(v(1, 1, 4, 0, 0));
        tbl.push_back(v(0, 1, 4, 4, 0));
        tbl.push_back(v(0, 1, 4, 3, 0));
        tbl.push_back(v(0, 1, 4, 2, 0));
        tbl.push_back(v(0, 1, 4, 1, 0));
        tbl.push_back(v(0, 1, 4, 0, 1));
        tbl.push_back(v(0, 1, 4, 4, 0));
        tbl.push_back(v(0, 1, 4, 3, 0));
        tbl.push_back(v(0, 1, 4, 2, 0));
        tbl.push_back(v(0, 1, 4, 1, 0));
        tbl.push_back(v(0, 1, 4, 0, 1));
        tbl.push_back(v(0, 1, 4, 4, 0));
        // interval 9 changed to 3 while remain is 5
        tbl.push_back(v(1, 1, 9, 0, 0));
        tbl.push_back(v(0, 1, 9, 9, 0));
        tbl.push_back(v(0, 1, 9, 8, 0));
        tbl.push_back(v(0, 1, 9, 7, 0));
        tbl.push_back(v(0, 1, 9, 6, 0));
        tbl.push_back(v(0, 1, 9, 5, 0));
        tbl.push_back(v(0, 1, 3, 4, 0));
        tbl.push_back(v(0, 1, 3, 3, 0));
        tbl.push_back(v(0, 1, 3, 2, 0));
        tbl.push_back(v(0, 1, 3, 1, 0));
        tbl.push_back(v(0, 1, 3, 0, 1));
        tbl.push_back(v(0, 1, 3, 3, 0));
        tbl.push_back(v(0, 1, 3, 2, 0));
        tbl.push_back(v(0, 1, 3, 1, 0));
        tbl.push_back(v(0, 1, 3, 0, 1));
        tbl.push_back(v(0, 1, 3, 3, 0));
        tbl.push_back(v(0, 0, 3, 0, 0));
        tbl.push_back(v(0, 1, 3, 0, 0));
        tbl.push_back(v(0, 1, 3, 3, 0));
        step();
        do_reset();
        chk("reset remain", bus_a.remain, 0);
        chk("reset pulse", 32'(bus_a.gene_pulse), 0);
        chk("reset levelup", 32'(bus_a.levelup), 0);
        chk("reset level", 32'(bus_a.level), 0);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rs) do_reset();
            bus_a.en = tbl[i].en;
            bus_a.gene_time = tbl[i].gt;
            step();
            chk($sformatf("tbl[%0d] remain", i), bus_a.remain, tbl[i].rem);
            chk($sformatf("tbl[%0d] pulse", i), 32'(bus_a.gene_pulse), 32'(tbl[i].pul));
        end
        // GEN_PER_LEVEL=4, interval 2: pulses at edges 4,7,..,25; levelup at 14 and 26
        do_reset();
        bus_a.en = 1'b1; bus_a.gene_time = 2;
        for (int k = 1; k <= 28; k++) begin
            step();
            chk($sformatf("lvl k%0d pulse", k), 32'(bus_a.gene_pulse), 32'(k >= 4 && (k - 4) % 3 == 0));
            chk($sformatf("lvl k%0d levelup", k), 32'(bus_a.levelup), 32'(k == 14 || k == 26));
            chk($sformatf("lvl k%0d level", k), 32'(bus_a.level), k >= 26 ? 2 : k >= 14 ? 1 : 0);
        end
        // MAX_LEVEL=2, GEN_PER_LEVEL=1, interval 0: second levelup deferred one cycle, then saturate
        do_reset();
        bus_b.en = 1'b1; bus_b.gene_time = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("sat k%0d pulse", k), 32'(bus_b.gene_pulse), 32'(k >= 2));
            chk($sformatf("sat k%0d levelup", k), 32'(bus_b.levelup), 32'(k == 3 || k == 5));
            chk($sformatf("sat k%0d level", k), 32'(bus_b.level), k >= 5 ? 2 : k >= 3 ? 1 : 0);
        end
        // en falls while the 4th pulse is visible: pulse counts, levelup still issues, level held
        do_reset();
        bus_a.en = 1'b1; bus_a.gene_time = 0;
        repeat (5) step();
        chk("drop pulse4", 32'(bus_a.gene_pulse), 1);
        bus_a.en = 1'b0;
        step();
        chk("drop pulse", 32'(bus_a.gene_pulse), 0);
        chk("drop remain", bus_a.remain, 0);
        chk("drop levelup", 32'(bus_a.levelup), 1);
        chk("drop level", 32'(bus_a.level), 1);
        step();
        chk("drop levelup2", 32'(bus_a.levelup), 0);
        chk("drop level2", 32'(bus_a.level), 1);
        bus_a.en = 1'b1;
        step();
        chk("reen load pulse", 32'(bus_a.gene_pulse), 0);
        step();
        chk("reen pulse", 32'(bus_a.gene_pulse), 1);
        chk("reen level", 32'(bus_a.level), 1);
        // async reset mid-interval with remain 7 after 3 pulses
        do_reset();
        bus_a.en = 1'b1; bus_a.gene_time = 9;
        repeat (34) step();
        chk("arst pre remain", bus_a.remain, 7);
        #2 rst = 1'b1;
        #1;
        chk("arst remain", bus_a.remain, 0);
        chk("arst pulse", 32'(bus_a.gene_pulse), 0);
        chk("arst levelup", 32'(bus_a.levelup), 0);
        chk("arst level", 32'(bus_a.level), 0);
        bus_a.en = 1'b0;
        step();
        chk("arst hold pulse", 32'(bus_a.gene_pulse), 0);
        rst = 1'b0;
        bus_a.en = 1'b1; bus_a.gene_time = 0;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("arst k%0d levelup", k), 32'(bus_a.levelup), 32'(k == 6));
        end
        chk("arst level after", 32'(bus_a.level), 1);
`ifdef GENERATE_TIMER_PAUSE_EN
        do_reset();
        bus_a.en = 1'b1; bus_a.gene_time = 5;
        repeat (4) step();
        chk("pause pre remain", bus_a.remain, 3);
        bus_a.pause = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("pause k%0d remain", k), bus_a.remain, 3);
            chk($sformatf("pause k%0d pulse", k), 32'(bus_a.gene_pulse), 0);
        end
        bus_a.pause = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("resume k%0d remain", k), bus_a.remain, 32'(4 - k));
            chk($sformatf("resume k%0d pulse", k), 32'(bus_a.gene_pulse), 32'(k == 4));
        end
`endif
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
